cross2x2_arbiter: RTL and testbench
===================================

Name: cross2x2_arbiter

Overview:
- Controller and registered datapath for the 2x2 crossbar.
- Two sources send single- or multi-beat packets, each addressed to one of two destinations.
- A per-output round-robin arbiter resolves contention and locks the output to its winner until the packet's last beat.
- The arbiter drives the crossbar selects and registers the output stage, giving 1-cycle latency.

Parameters:
- DATA_W, 2, width of each data beat.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in0_valid  in  1  source 0 beat valid.
- in0_last  in  1  source 0 beat is last of packet.
- in0_dest  in  1  source 0 target output (0/1); sampled at packet start.
- in0_data  in  DATA_W  source 0 beat.
- in0_ready  out  1  source 0 beat accepted this cycle when in0_valid && in0_ready.
- in1_valid, in1_last, in1_dest, in1_data, in1_ready: same as source 0, for source 1.
- out0_valid  out  1  output 0 beat valid.
- out0_data  out  DATA_W  output 0 beat.
- out0_last  out  1  output 0 beat is last.
- out0_src  out  1  source index of the out0 beat (the crossbar Sel0 value).
- out0_ready  in  1  downstream accepts output 0 beat.
- out1_valid, out1_data, out1_last, out1_src, out1_ready: same as output 0; out1_src is the Sel1 value.

Behaviour:
- Reset: out*_valid=0, out*_data=0, out*_last=0, out*_src=0, in*_ready=0, both output FSMs IDLE, rr_ptr[0]=rr_ptr[1]=0 (source 0 favoured).
- Reset mid-packet drops all locks and any registered beat. No partial-packet recovery.
- Per output j, FSM states IDLE and LOCKED (owner[j] holds the source index).
- Output slot j is free when !outj_valid || outj_ready.
- IDLE, candidates: sources i with ini_valid, ini_dest==j, and i not LOCKED on the other output.
  - One candidate: it wins.
  - Two candidates: rr_ptr[j] wins.
  - Winner's beat transfers in the same cycle only if slot j is free.
- LOCKED: only owner[j] is eligible. Its in_dest is ignored (it must stay stable; not checked). A beat transfers when owner valid and slot j is free.
- ini_ready = 1 exactly when source i is the winner/owner of some output j and slot j is free. Ready is combinational from state, valid, dest and out_ready. Valid never depends on ready.
- Transfer into output j: next cycle outj_valid=1, outj_data/last/src = source beat and index. Latency is 1 cycle. Back-to-back beats sustain 1 beat/cycle when outj_ready=1.
- Slot j with no new transfer and outj_ready=1: outj_valid clears. outj_data is held, not cleared.
- outj_valid=1 and outj_ready=0: data, last and src are held stable.
- Transfer with last=1: FSM goes to (or stays) IDLE, rr_ptr[j] <= ~winner.
- Transfer with last=0: FSM goes LOCKED with owner[j]=winner; rr_ptr unchanged until the packet ends.
- rr_ptr updates only on the last beat of a contended or uncontended packet.
- Both sources targeting different outputs proceed fully in parallel.
- One source is never granted both outputs: a source locked on j is excluded from j's complement.
- Single-beat packet (last=1 on first beat) never enters LOCKED.

Decomposition:
- Package cross2x2_pkg holds:
  - typedef state_t {IDLE, LOCKED};
  - localparam NUM_PORTS=2;
  - typedef src_idx_t (1 bit).
- One sub-module, cross2x2_out_arb, instantiated twice (one per output). Contents: FSM, owner, rr_ptr, output register, parameterised by output index.
- The top level computes cross-exclusion and ORs the per-output ready terms into in*_ready.

Test Plan:
- Reset: assert rst 2 cycles with in0_valid=1 -> all out*_valid=0, out*_src=0, in*_ready=0. First cycle after release, in0 (dest 0, data 2'b10, last 1) is accepted; next cycle out0_valid=1, out0_data=2'b10, out0_src=0.
- Parallel: in0 dest 1 data 2'b01, in1 dest 0 data 2'b11, both last, out*_ready=1 -> both in_ready=1 the same cycle. Next cycle out1_data=01 with out1_src=0, and out0_data=11 with out0_src=1.
- Contention round-robin: both sources send 1-beat packets to dest 0 continuously, out0_ready=1 -> out0_src sequence 0,1,0,1.
- Packet lock: in1 sends a 3-beat packet (last on beat 3) to dest 0 while in0 also requests dest 0 -> out0_src=1 for 3 consecutive beats. in0_ready=0 until beat 3 is accepted; then in0 is granted.
- Backpressure: out0_ready=0 for 4 cycles after out0_valid=1 -> out0_data/src held, sources targeting 0 see ready=0, and no beat is lost or duplicated.
- Reset mid-packet: rst during beat 2 of a 3-beat packet -> both FSMs IDLE. A new packet from the other source is granted immediately after release.

Source files
------------

// File: rtl/cross2x2_pkg.sv
// cross2x2_pkg
// Shared types and constants for the 2x2 crossbar arbiter slice.
//   state_t   : per-output arbitration state (IDLE / LOCKED)
//   src_idx_t : index of a source port (one bit for two sources)
//   NUM_PORTS : number of sources and number of outputs
package cross2x2_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic [0:0] src_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Round-robin hand-off: after a packet ends, the other source is favoured.
  function automatic src_idx_t other_src(input src_idx_t s);
    return ~s;
  endfunction

endpackage

// File: rtl/cross2x2_out_arb.sv
// cross2x2_out_arb
// Arbiter, packet lock and registered output stage for one crossbar output.
// Instantiated once per output; OUT_IDX selects which destination it serves.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/last/dest    : per-source beat qualifiers (bit i = source i)
//   in_data               : per-source beat data
//   excl                  : bit i set when source i is locked on the other output
//   out_ready             : downstream accepts the registered beat
//   out_valid/data/last   : registered output beat
//   out_src               : source index of the registered beat (crossbar select)
//   grant                 : bit i set when source i's beat transfers this cycle
//   locked, owner         : lock status, used by the top for cross-exclusion
module cross2x2_out_arb
  import cross2x2_pkg::*;
#(
  parameter int DATA_W  = 2,
  parameter int OUT_IDX = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                in_valid,
  input  logic [NUM_PORTS-1:0]                in_last,
  input  logic [NUM_PORTS-1:0]                in_dest,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    in_data,
  input  logic [NUM_PORTS-1:0]                excl,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [DATA_W-1:0]                   out_data,
  output logic                                out_last,
  output src_idx_t                            out_src,
  output logic [NUM_PORTS-1:0]                grant,
  output logic                                locked,
  output src_idx_t                            owner
);

  localparam logic MY_IDX = 1'(OUT_IDX);

  state_t                state, state_nxt;
  src_idx_t              owner_q, owner_nxt;
  src_idx_t              rr_ptr, rr_nxt;
  src_idx_t              winner;
  logic                  has_win;
  logic                  slot_free;
  logic                  xfer;
  logic [NUM_PORTS-1:0]  req;

  // A source is a candidate for a fresh packet only if it targets this
  // output and is not already holding the other output.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = in_valid[i] && (in_dest[i] == MY_IDX) && !excl[i];
    end
  end

  // Pick the winner: round-robin between two fresh candidates, or the
  // current owner while a multi-beat packet is in flight.
  always_comb begin
    winner  = '0;
    has_win = 1'b0;
    case (state)
      IDLE: begin
        case (req)
          2'b11: begin
            winner  = rr_ptr;
            has_win = 1'b1;
          end
          2'b01: begin
            winner  = 1'b0;
            has_win = 1'b1;
          end
          2'b10: begin
            winner  = 1'b1;
            has_win = 1'b1;
          end
          default: begin
            winner  = '0;
            has_win = 1'b0;
          end
        endcase
      end
      LOCKED: begin
        winner  = owner_q;
        has_win = in_valid[owner_q];
      end
      default: begin
        winner  = '0;
        has_win = 1'b0;
      end
    endcase
  end

  // The output register can take a beat when empty or draining this cycle.
  // Reset suppresses any transfer so ready reads low while rst is high.
  always_comb begin
    slot_free = !out_valid || out_ready;
    xfer      = has_win && slot_free && !rst;
    grant     = '0;
    grant[0]  = xfer && (winner == 1'b0);
    grant[1]  = xfer && (winner == 1'b1);
  end

  // Next-state: a last beat releases the output and hands priority to the
  // other source; a non-last beat locks the output to the winner.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner_q;
    rr_nxt    = rr_ptr;
    if (xfer) begin
      if (in_last[winner]) begin
        state_nxt = IDLE;
        rr_nxt    = other_src(winner);
      end else begin
        state_nxt = LOCKED;
        owner_nxt = winner;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      owner_q <= owner_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  // Output stage: load on transfer, otherwise drop valid once consumed.
  // Data, last and src are left untouched when not loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[winner];
      out_last  <= in_last[winner];
      out_src   <= winner;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign locked = (state == LOCKED);
  assign owner  = owner_q;

endmodule

// File: rtl/cross2x2_arbiter.sv
// cross2x2_arbiter
// 2x2 crossbar controller with registered outputs (1-cycle latency).
// Two sources send packets to one of two outputs; each output has its own
// round-robin arbiter that locks to a winner until the packet's last beat.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   inN_valid/last/dest/data, ready  : source N handshake (N = 0,1)
//   outM_valid/data/last/src, ready  : output M handshake (M = 0,1)
module cross2x2_arbiter
  import cross2x2_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic              in0_last,
  input  logic              in0_dest,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic              in1_last,
  input  logic              in1_dest,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out0_valid,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out0_src,
  input  logic              out0_ready,
  output logic              out1_valid,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic              out1_src,
  input  logic              out1_ready
);

  logic [NUM_PORTS-1:0]             in_valid;
  logic [NUM_PORTS-1:0]             in_last;
  logic [NUM_PORTS-1:0]             in_dest;
  logic [NUM_PORTS-1:0][DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]             excl0, excl1;
  logic [NUM_PORTS-1:0]             grant0, grant1;
  logic                             locked0, locked1;
  src_idx_t                         owner0, owner1;
  src_idx_t                         src0, src1;

  assign in_valid = {in1_valid, in0_valid};
  assign in_last  = {in1_last,  in0_last};
  assign in_dest  = {in1_dest,  in0_dest};
  assign in_data  = {in1_data,  in0_data};

  // Cross-exclusion: a source holding one output may not start a packet
  // on the other, so no source is ever granted both outputs.
  always_comb begin
    excl0 = '0;
    excl1 = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      excl0[i] = locked1 && (owner1 == src_idx_t'(i));
      excl1[i] = locked0 && (owner0 == src_idx_t'(i));
    end
  end

  cross2x2_out_arb #(.DATA_W(DATA_W), .OUT_IDX(0)) u_arb0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .excl      (excl0),
    .out_ready (out0_ready),
    .out_valid (out0_valid),
    .out_data  (out0_data),
    .out_last  (out0_last),
    .out_src   (src0),
    .grant     (grant0),
    .locked    (locked0),
    .owner     (owner0)
  );

  cross2x2_out_arb #(.DATA_W(DATA_W), .OUT_IDX(1)) u_arb1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .excl      (excl1),
    .out_ready (out1_ready),
    .out_valid (out1_valid),
    .out_data  (out1_data),
    .out_last  (out1_last),
    .out_src   (src1),
    .grant     (grant1),
    .locked    (locked1),
    .owner     (owner1)
  );

  assign out0_src  = src0;
  assign out1_src  = src1;

  // A source is ready when whichever output it is transferring into grants it.
  assign in0_ready = grant0[0] | grant1[0];
  assign in1_ready = grant0[1] | grant1[1];

endmodule

// File: tb/tb_cross2x2_arbiter.sv
// tb_cross2x2_arbiter
// Directed scenarios followed by random traffic, checked every cycle against
// a behavioural model of the crossbar's arbitration rules.
module tb_cross2x2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv[2];
  logic       il[2];
  logic       idst[2];
  logic [1:0] idat[2];
  logic       ordy[2];

  logic       in0_ready, in1_ready;
  logic       out0_valid, out0_last, out0_src;
  logic       out1_valid, out1_last, out1_src;
  logic [1:0] out0_data, out1_data;

  int vectors = 0;
  int miscompares = 0;

  // Model state: per output, lock flag, owner, favoured source, output beat.
  int         m_lock[2];
  int         m_owner[2];
  int         m_rr[2];
  logic       m_ov[2];
  logic [1:0] m_od[2];
  logic       m_ol[2];
  logic       m_os[2];
  int         win[2];
  bit         xf[2];
  logic       exp_rdy[2];
  bit         acc[2];

  // Random source generators.
  int rem[2];

  always #5 clk = ~clk;

  cross2x2_arbiter #(.DATA_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in0_valid  (iv[0]),
    .in0_last   (il[0]),
    .in0_dest   (idst[0]),
    .in0_data   (idat[0]),
    .in0_ready  (in0_ready),
    .in1_valid  (iv[1]),
    .in1_last   (il[1]),
    .in1_dest   (idst[1]),
    .in1_data   (idat[1]),
    .in1_ready  (in1_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out0_src   (out0_src),
    .out0_ready (ordy[0]),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .out1_src   (out1_src),
    .out1_ready (ordy[1])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_lock[j]  = 0;
      m_owner[j] = 0;
      m_rr[j]    = 0;
      m_ov[j]    = 1'b0;
      m_od[j]    = 2'b00;
      m_ol[j]    = 1'b0;
      m_os[j]    = 1'b0;
    end
  endtask

  // Who may transfer this cycle, derived from the arbitration rules.
  task automatic model_comb();
    for (int j = 0; j < 2; j++) begin
      bit free;
      bit has;
      int n;
      free  = !m_ov[j] || ordy[j];
      xf[j] = 0;
      win[j] = 0;
      has = 0;
      if (m_lock[j] != 0) begin
        win[j] = m_owner[j];
        has = iv[win[j]];
      end else begin
        n = 0;
        for (int i = 0; i < 2; i++) begin
          if (iv[i] && int'(idst[i]) == j && !(m_lock[1-j] != 0 && m_owner[1-j] == i)) begin
            n++;
            win[j] = i;
          end
        end
        if (n == 2) win[j] = m_rr[j];
        has = (n > 0);
      end
      xf[j] = has && free && !rst;
    end
    for (int i = 0; i < 2; i++) begin
      exp_rdy[i] = (xf[0] && win[0] == i) || (xf[1] && win[1] == i);
      acc[i] = exp_rdy[i] && iv[i];
    end
  endtask

  task automatic model_seq();
    if (rst) begin
      model_reset();
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (xf[j]) begin
          m_ov[j] = 1'b1;
          m_od[j] = idat[win[j]];
          m_ol[j] = il[win[j]];
          m_os[j] = 1'(win[j]);
          if (il[win[j]]) begin
            m_lock[j] = 0;
            m_rr[j] = 1 - win[j];
          end else begin
            m_lock[j] = 1;
            m_owner[j] = win[j];
          end
        end else if (ordy[j]) begin
          m_ov[j] = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic d0, input logic l0, input logic [1:0] x0,
                               input logic v1, input logic d1, input logic l1, input logic [1:0] x1);
    iv[0] = v0; idst[0] = d0; il[0] = l0; idat[0] = x0;
    iv[1] = v1; idst[1] = d1; il[1] = l1; idat[1] = x1;
  endtask

  task automatic checkOutput();
    check("out0_valid", 8'(out0_valid), 8'(m_ov[0]));
    check("out0_data",  8'(out0_data),  8'(m_od[0]));
    check("out0_last",  8'(out0_last),  8'(m_ol[0]));
    check("out0_src",   8'(out0_src),   8'(m_os[0]));
    check("out1_valid", 8'(out1_valid), 8'(m_ov[1]));
    check("out1_data",  8'(out1_data),  8'(m_od[1]));
    check("out1_last",  8'(out1_last),  8'(m_ol[1]));
    check("out1_src",   8'(out1_src),   8'(m_os[1]));
  endtask

  // One clock: check readies mid-cycle, advance model, check registers after edge.
  task automatic tick();
    #2;
    model_comb();
    check("in0_ready", 8'(in0_ready), 8'(exp_rdy[0]));
    check("in1_ready", 8'(in1_ready), 8'(exp_rdy[1]));
    model_seq();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic pat[4];
    model_reset();
    rem[0] = 0;
    rem[1] = 0;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;

    // Reset held with a pending beat.
    rst = 1'b1;
    applyStimulus(1, 0, 1, 2'b10, 0, 0, 0, 2'b00);
    tick();
    tick();
    check("rst_out0_valid", 8'(out0_valid), 8'd0);
    check("rst_out1_valid", 8'(out1_valid), 8'd0);
    check("rst_out0_src", 8'(out0_src), 8'd0);

    // First beat after release is accepted.
    rst = 1'b0;
    tick();
    check("first_out0_data", 8'(out0_data), 8'h2);
    check("first_out0_src", 8'(out0_src), 8'd0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);

    // Parallel transfers to different outputs.
    applyStimulus(1, 1, 1, 2'b01, 1, 0, 1, 2'b11);
    #1;
    check("par_in0_ready", 8'(in0_ready), 8'd1);
    check("par_in1_ready", 8'(in1_ready), 8'd1);
    tick();
    check("par_out1_data", 8'(out1_data), 8'h1);
    check("par_out1_src", 8'(out1_src), 8'd0);
    check("par_out0_data", 8'(out0_data), 8'h3);
    check("par_out0_src", 8'(out0_src), 8'd1);

    // Contention with single-beat packets alternates sources.
    pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1;
    applyStimulus(1, 0, 1, 2'b00, 1, 0, 1, 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_out0_src", 8'(out0_src), 8'(pat[k]));
    end
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);

    // Three-beat packet from source 1 holds output 0 against source 0.
    applyStimulus(0, 0, 0, 2'b00, 1, 0, 0, 2'b01);
    tick();
    check("lock_src_b1", 8'(out0_src), 8'd1);
    applyStimulus(1, 0, 1, 2'b11, 1, 0, 0, 2'b10);
    #1;
    check("lock_in0_ready_b2", 8'(in0_ready), 8'd0);
    tick();
    check("lock_src_b2", 8'(out0_src), 8'd1);
    applyStimulus(1, 0, 1, 2'b11, 1, 0, 1, 2'b00);
    #1;
    check("lock_in0_ready_b3", 8'(in0_ready), 8'd0);
    tick();
    check("lock_src_b3", 8'(out0_src), 8'd1);
    check("lock_last_b3", 8'(out0_last), 8'd1);
    applyStimulus(1, 0, 1, 2'b11, 0, 0, 0, 2'b00);
    tick();
    check("lock_release_src", 8'(out0_src), 8'd0);
    check("lock_release_data", 8'(out0_data), 8'h3);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);

    // Backpressure on output 0 for four cycles.
    applyStimulus(1, 0, 1, 2'b01, 0, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 0, 1, 2'b10, 0, 0, 0, 2'b00);
    ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_out0_data", 8'(out0_data), 8'h1);
      check("bp_out0_valid", 8'(out0_valid), 8'd1);
    end
    ordy[0] = 1'b1;
    tick();
    check("bp_next_data", 8'(out0_data), 8'h2);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    tick();
    check("bp_drain_valid", 8'(out0_valid), 8'd0);
    check("bp_drain_hold", 8'(out0_data), 8'h2);

    // Reset in the middle of a packet, then a new packet from the other source.
    applyStimulus(1, 1, 0, 2'b01, 0, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 1, 0, 2'b10, 0, 0, 0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 1, 1, 1, 2'b11);
    #1;
    check("mid_rst_in1_ready", 8'(in1_ready), 8'd1);
    tick();
    check("mid_rst_out1_src", 8'(out1_src), 8'd1);
    check("mid_rst_out1_data", 8'(out1_data), 8'h3);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    tick();

    // Random packet traffic with random backpressure and rare resets.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) != 0) begin
          rem[i]  = int'($urandom_range(1, 3));
          idst[i] = 1'($urandom_range(0, 1));
          idat[i] = 2'($urandom_range(0, 3));
        end
        iv[i] = (rem[i] > 0) && ($urandom_range(0, 3) != 0);
        il[i] = (rem[i] == 1);
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          rem[i] = 0;
        end else if (acc[i]) begin
          rem[i]--;
          idat[i] = 2'($urandom_range(0, 3));
        end
      end
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
